// File: rtl/modn_cnt_pkg.sv
// Shared definitions for the modulo-N counter family: direction encodings,
// the parameter range check and the update-source selector.
package modn_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Which source feeds the count register on the coming edge.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_RST   = 2'd1,
    SEL_LOAD  = 2'd2,
    SEL_COUNT = 2'd3
  } upd_sel_e;

  // The modulus must span at least two states and fit the counter width.
  function automatic bit modn_range_ok(input int width, input int modulus);
    bit ok;
    ok = (width >= 1) && (width <= 16) &&
         (modulus >= 2) && (modulus <= (1 << width));
    return ok;
  endfunction

endpackage

// File: rtl/modn_cnt_next.sv
// Combinational next-count generator for a modulo-N counter.
// Produces the value one step up or down from q, honouring wrap/saturate at
// the range ends, plus a flag telling whether q sits on the boundary for the
// requested direction. Shared by the register update and the TC output.
module modn_next
  import modn_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter bit WRAP    = 1'b1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             at_bound
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] Q_MIN = '0;

  // Boundary detection and next-value choice; no arithmetic crosses the
  // range ends, so WIDTH bits never overflow.
  always_comb begin
    q_next   = q;
    at_bound = 1'b0;
    if (up == CNT_UP) begin
      at_bound = (q == Q_MAX);
      if (at_bound) begin
        q_next = WRAP ? Q_MIN : q;
      end else begin
        q_next = q + WIDTH'(1);
      end
    end else if (up == CNT_DN) begin
      at_bound = (q == Q_MIN);
      if (at_bound) begin
        q_next = WRAP ? Q_MAX : q;
      end else begin
        q_next = q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modn_cnt.sv
// Parametrised modulo-N counter: up/down, synchronous load with range check,
// wrap or saturate at the ends, and a combinational terminal count that can
// drive the CE of the next digit in a cascade.
module modn_cnt
  import modn_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter bit WRAP    = 1'b1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             ERR
);

  if (!modn_range_ok(WIDTH, MODULUS)) begin : g_bad_param
    $error("modn_cnt: MODULUS must be in 2..2**WIDTH and WIDTH in 1..16");
  end

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_reg;
  logic             err_reg;
  logic [WIDTH-1:0] q_step;
  logic             at_bound;
  logic             ld_in_range;
  logic [WIDTH-1:0] ld_value;
  upd_sel_e         sel;

  modn_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .WRAP    (WRAP)
  ) u_next (
    .q        (q_reg),
    .up       (UP),
    .q_next   (q_step),
    .at_bound (at_bound)
  );

  // Out-of-range loads clamp to the top of the range instead of escaping it.
  assign ld_in_range = (32'(D) < MODULUS);
  assign ld_value    = ld_in_range ? D : Q_MAX;

  // Priority select: reset over load over count.
  always_comb begin
    sel = SEL_HOLD;
    if (R) begin
      sel = SEL_RST;
    end else if (LD) begin
      sel = SEL_LOAD;
    end else if (CE) begin
      sel = SEL_COUNT;
    end
  end

  // Count and sticky error registers.
  always_ff @(posedge CLK) begin
    case (sel)
      SEL_RST: begin
        q_reg   <= '0;
        err_reg <= 1'b0;
      end
      SEL_LOAD: begin
        q_reg <= ld_value;
        if (!ld_in_range) begin
          err_reg <= 1'b1;
        end
      end
      SEL_COUNT: begin
        q_reg <= q_step;
      end
      default: begin
        q_reg <= q_reg;
      end
    endcase
  end

  // TC only in a genuine count cycle, so a cascade never steps on R or LD.
  assign TC  = (sel == SEL_COUNT) && at_bound;
  assign Q   = q_reg;
  assign ERR = err_reg;

endmodule

// File: tb/tb_modn_cnt.sv
// Self-checking bench for modn_cnt: mod-6 wrap and saturate instances driven
// in parallel against a reference model, plus a mod-10/mod-6 cascade.
module tb_modn_cnt;

  localparam int M6 = 6;

  logic       CLK = 1'b0;
  logic       R = 1'b0, CE = 1'b0, UP = 1'b1, LD = 1'b0;
  logic [3:0] D = '0;
  logic [3:0] q_w, q_s;
  logic       tc_w, tc_s, err_w, err_s;

  logic       c_r = 1'b0, c_ce = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_err, hi_err;

  int n_cmp = 0;
  int n_err = 0;

  int m_q[2];
  int m_err[2];
  bit m_valid = 1'b0;
  int c_cnt = 0;
  bit c_valid = 1'b0;

  always #5 CLK = ~CLK;

  modn_cnt #(.WIDTH(4), .MODULUS(6), .WRAP(1'b1)) dut_wrap (
    .CLK(CLK), .R(R), .CE(CE), .UP(UP), .LD(LD), .D(D),
    .Q(q_w), .TC(tc_w), .ERR(err_w));

  modn_cnt #(.WIDTH(4), .MODULUS(6), .WRAP(1'b0)) dut_sat (
    .CLK(CLK), .R(R), .CE(CE), .UP(UP), .LD(LD), .D(D),
    .Q(q_s), .TC(tc_s), .ERR(err_s));

  modn_cnt #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) dut_lo (
    .CLK(CLK), .R(c_r), .CE(c_ce), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .Q(lo_q), .TC(lo_tc), .ERR(lo_err));

  modn_cnt #(.WIDTH(4), .MODULUS(6), .WRAP(1'b1)) dut_hi (
    .CLK(CLK), .R(c_r), .CE(lo_tc), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .Q(hi_q), .TC(hi_tc), .ERR(hi_err));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: wrap is modular arithmetic, saturate is a clamp.
  function automatic int ref_count(input int q, input bit wrap, input bit up, input int m);
    if (wrap) return up ? (q + 1) % m : (q + m - 1) % m;
    if (up) return (q + 1 > m - 1) ? m - 1 : q + 1;
    return (q - 1 < 0) ? 0 : q - 1;
  endfunction

  function automatic bit ref_tc(input int q, input bit r, input bit ld, input bit ce,
                                input bit up, input int m);
    return ce && !r && !ld && ((up && q == m - 1) || (!up && q == 0));
  endfunction

  task automatic step(input bit r, input bit ld, input bit ce, input bit up, input int d);
    bit wrap_of[2];
    wrap_of[0] = 1'b1;
    wrap_of[1] = 1'b0;
    R = r; LD = ld; CE = ce; UP = up; D = 4'(d);
    #1;
    if (m_valid) begin
      chk("tc_wrap", int'(tc_w), int'(ref_tc(m_q[0], r, ld, ce, up, M6)));
      chk("tc_sat",  int'(tc_s), int'(ref_tc(m_q[1], r, ld, ce, up, M6)));
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_q[i] = 0;
        m_err[i] = 0;
      end else if (ld) begin
        if (d < M6) m_q[i] = d;
        else begin
          m_q[i] = M6 - 1;
          m_err[i] = 1;
        end
      end else if (ce) begin
        m_q[i] = ref_count(m_q[i], wrap_of[i], up, M6);
      end
    end
    if (r) m_valid = 1'b1;
    if (m_valid) begin
      chk("q_wrap",   int'(q_w),   m_q[0]);
      chk("q_sat",    int'(q_s),   m_q[1]);
      chk("err_wrap", int'(err_w), m_err[0]);
      chk("err_sat",  int'(err_s), m_err[1]);
    end
  endtask

  task automatic cstep(input bit r, input bit ce);
    c_r = r; c_ce = ce;
    #1;
    if (c_valid) begin
      chk("c_lo_tc", int'(lo_tc), int'(!r && ce && (c_cnt % 10 == 9)));
      chk("c_hi_tc", int'(hi_tc), int'(!r && ce && c_cnt == 59));
    end
    @(posedge CLK);
    #1;
    if (r) begin
      c_cnt = 0;
      c_valid = 1'b1;
    end else if (ce) begin
      c_cnt = (c_cnt + 1) % 60;
    end
    if (c_valid) chk("c_count", int'(hi_q) * 10 + int'(lo_q), c_cnt);
  endtask

  initial begin
    int up_seq[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int dn_seq[3] = '{0, 5, 4};
    int sat_seq[4] = '{5, 5, 5, 5};

    repeat (2) @(posedge CLK);
    #1;

    // Reset then count up with wrap.
    step(1, 0, 0, 1, 0);
    chk("rst_q", int'(q_w), 0);
    chk("rst_err", int'(err_w), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 0);
      chk("up_seq", int'(q_w), up_seq[i]);
    end

    // Count down with wrap from 1.
    step(0, 1, 0, 0, 1);
    chk("dn_load", int'(q_w), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("dn_seq", int'(q_w), dn_seq[i]);
    end

    // Saturation from 4, then reverse.
    step(0, 1, 0, 1, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0);
      chk("sat_seq", int'(q_s), sat_seq[i]);
    end
    step(0, 0, 1, 0, 0);
    chk("sat_rev", int'(q_s), 4);

    // Out-of-range load, sticky error, clear on reset.
    step(0, 1, 0, 1, 9);
    chk("ld9_q", int'(q_w), 5);
    chk("ld9_err", int'(err_w), 1);
    step(0, 1, 0, 1, 2);
    chk("ld2_q", int'(q_w), 2);
    chk("ld2_err", int'(err_w), 1);
    step(0, 0, 1, 1, 0);
    chk("cnt_err", int'(err_w), 1);
    step(1, 0, 0, 1, 0);
    chk("rst_clr", int'(err_w), 0);

    // Priority cases.
    step(0, 1, 0, 1, 5);
    step(1, 1, 1, 1, 3);
    chk("pri_rst", int'(q_w), 0);
    step(0, 1, 1, 1, 5);
    R = 0; LD = 1; CE = 1; UP = 1; D = 4'd3;
    #1;
    chk("pri_ld_tc", int'(tc_w), 0);
    step(0, 1, 1, 1, 3);
    chk("pri_ld_q", int'(q_w), 3);
    step(0, 0, 1, 1, 0);
    chk("mid_q4", int'(q_w), 4);
    step(1, 0, 1, 1, 0);
    chk("mid_rst", int'(q_w), 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31, 0) == 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(3, 0) != 0), 1'($urandom), int'($urandom_range(15, 0)));
    end

    // Cascade: 60 enabled cycles from reset, then random enables.
    cstep(1, 0);
    for (int i = 0; i < 60; i++) cstep(0, 1);
    chk("c_wrap00", int'(hi_q) * 10 + int'(lo_q), 0);
    for (int i = 0; i < 150; i++) cstep(0, ($urandom_range(3, 0) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
